// File: rtl/cnn_pkg.sv
// Shared types for the convolution datapath: collector FSM states, pixel type
// and a width helper for the raster counters.
package cnn_pkg;

    localparam int PIXEL_W = 8;

    typedef logic signed [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_e;

    // Counter width for an index in 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major (row, col) position counter with wrap and end-of-map detect,
// advancing only when the caller reports a handshake.
module raster_counter
    import cnn_pkg::*;
#(
    parameter  int OUT_SIZE = 5,
    localparam int CW       = cnt_width(OUT_SIZE)
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          at_end
);

    localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row    = row_q;
    assign col    = col_q;
    assign at_end = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/fmap_collector.sv
// Captures a raster-ordered stream of convolution results into an
// OUT_SIZE x OUT_SIZE map (optional ReLU on write), then streams it back out.
module fmap_collector
    import cnn_pkg::*;
#(
    parameter int OUT_SIZE  = 5,
    parameter int WIDTH_BIT = 8,
    parameter int RELU      = 1
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_BIT-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_BIT-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = cnt_width(OUT_SIZE);

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic [CW-1:0] wr_row, wr_col, rd_row, rd_col;
    logic          wr_at_end, rd_at_end;
    logic          wr_en, rd_adv, cnt_clear;
    logic [WIDTH_BIT-1:0] wr_data;

    // Memory is left unreset: it is only ever read after a complete fill.
    logic [WIDTH_BIT-1:0] mem_q [OUT_SIZE][OUT_SIZE];

    // in_ready_q / out_valid_q are high only in FILL / DRAIN, so they gate the handshakes.
    assign wr_en     = in_valid & in_ready_q;
    assign rd_adv    = out_valid_q & out_ready;
    assign cnt_clear = (state_q == IDLE) & start;

    always_comb begin
        wr_data = in_data;
        if ((RELU != 0) && in_data[WIDTH_BIT-1]) begin
            wr_data = '0;
        end
    end

    raster_counter #(.OUT_SIZE(OUT_SIZE)) u_wr_cnt (
        .clock   (clock),
        .nreset  (nreset),
        .clear   (cnt_clear),
        .advance (wr_en),
        .row     (wr_row),
        .col     (wr_col),
        .at_end  (wr_at_end)
    );

    raster_counter #(.OUT_SIZE(OUT_SIZE)) u_rd_cnt (
        .clock   (clock),
        .nreset  (nreset),
        .clear   (cnt_clear),
        .advance (rd_adv),
        .row     (rd_row),
        .col     (rd_col),
        .at_end  (rd_at_end)
    );

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FILL;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            FILL: begin
                if (wr_en && wr_at_end) begin
                    state_d     = DRAIN;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DRAIN: begin
                if (rd_adv && rd_at_end) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_row][wr_col] <= wr_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = mem_q[rd_row][rd_col];
    assign out_last  = out_valid_q & rd_at_end;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fmap_collector.sv
// Bench for fmap_collector: a RELU=1 and a RELU=0 instance share all stimulus;
// a queue scoreboard checks readout order, out_last, stalls and the done pulse.
module tb_fmap_collector;
    import cnn_pkg::*;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    pixel_t      in_data = '0;
    logic        in_ready, out_valid, out_last, busy, done;
    logic [7:0]  out_data;
    logic        in_ready_n, out_valid_n, out_last_n, busy_n, done_n;
    logic [7:0]  out_data_n;

    always #5 clock = ~clock;

    fmap_collector #(.OUT_SIZE(5), .WIDTH_BIT(8), .RELU(1)) dut (
        .clock(clock), .nreset(nreset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    fmap_collector #(.OUT_SIZE(5), .WIDTH_BIT(8), .RELU(0)) dut_nr (
        .clock(clock), .nreset(nreset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_n), .in_data(in_data), .out_valid(out_valid_n),
        .out_ready(out_ready), .out_data(out_data_n), .out_last(out_last_n),
        .busy(busy_n), .done(done_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard state
    logic [7:0] q_r[$];
    logic [7:0] q_n[$];
    int         pops = 0;
    int         rd_idx = 0;
    logic       exp_done = 1'b0;
    logic       done_prev = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;

    always @(negedge clock) begin
        if (!nreset) begin
            q_r.delete();
            q_n.delete();
            rd_idx     = 0;
            exp_done   = 1'b0;
            done_prev  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (exp_done) begin
                chk("done_pulse", done, 1);
                chk("done_pulse_raw", done_n, 1);
                chk("busy_after_done", busy, 0);
                chk("out_valid_after_done", out_valid, 0);
            end else if (done_prev) begin
                chk("done_drop", done, 0);
            end else if (done) begin
                chk("spurious_done", done, 0);
            end
            done_prev = exp_done;
            exp_done  = 1'b0;
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_d);
                chk("stall_last", out_last, prev_l);
            end
            if (out_valid && out_ready) begin
                if (q_r.size() == 0) begin
                    chk("unexpected_out", q_r.size(), 1);
                end else begin
                    chk("out_data", out_data, q_r.pop_front());
                    chk("out_data_raw", out_data_n, q_n.pop_front());
                    chk("out_valid_raw", out_valid_n, 1);
                    chk("out_last", out_last, rd_idx == 24);
                    chk("out_last_raw", out_last_n, rd_idx == 24);
                end
                if (rd_idx == 24) begin
                    exp_done = 1'b1;
                    rd_idx   = 0;
                end else begin
                    rd_idx++;
                end
                pops++;
            end
            stall_prev = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    // Frame under test and its expected readouts for each instance
    pixel_t     cur[25];
    logic [7:0] exp_r[25];
    logic [7:0] exp_n[25];

    typedef struct {
        pixel_t din;
        pixel_t exp_relu;
        pixel_t exp_raw;
    } relu_vec_t;
    relu_vec_t rv[25];

    typedef struct {
        logic start;
        logic in_valid;
        logic exp_in_ready;
        logic exp_busy;
    } ctl_vec_t;
    ctl_vec_t cv[4];

    task automatic set_ramp(input int base);
        for (int i = 0; i < 25; i++) begin
            cur[i]   = pixel_t'(base + i);
            exp_r[i] = (cur[i] < 0) ? 8'd0 : cur[i];
            exp_n[i] = cur[i];
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("in_ready_after_start", in_ready, 1);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input int gaps, input int start_at, input int count);
        int n;
        for (int i = 0; i < count; i++) begin
            if (gaps != 0) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clock); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = cur[i];
            start    = (i == start_at);
            @(negedge clock);
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            q_r.push_back(exp_r[i]);
            q_n.push_back(exp_n[i]);
            @(posedge clock); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (count == 25) begin
            chk("first_out_valid", out_valid, 1);
            chk("in_ready_after_fill", in_ready, 0);
        end
    endtask

    task automatic drain(input int stall_at, input int stall_len, input int junk);
        int base, cyc, st;
        base = pops;
        cyc  = 0;
        st   = 0;
        while (pops - base < 25 && cyc < 300) begin
            if (pops - base == stall_at && st < stall_len) begin
                out_ready = 1'b0;
                st++;
            end else begin
                out_ready = 1'b1;
            end
            if (junk != 0 && (cyc == 4 || cyc == 9)) begin
                start    = 1'b1;
                in_valid = 1'b1;
                in_data  = 8'sh55;
            end else begin
                start    = 1'b0;
                in_valid = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (pops - base < 25) chk("drain_timeout", pops - base, 25);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cv[0] = '{start: 1'b0, in_valid: 1'b1, exp_in_ready: 1'b0, exp_busy: 1'b0};
        cv[1] = '{start: 1'b1, in_valid: 1'b0, exp_in_ready: 1'b0, exp_busy: 1'b0};
        cv[2] = '{start: 1'b0, in_valid: 1'b0, exp_in_ready: 1'b1, exp_busy: 1'b1};
        cv[3] = '{start: 1'b1, in_valid: 1'b0, exp_in_ready: 1'b1, exp_busy: 1'b1};
        for (int i = 0; i < 25; i++) begin
            if (i % 2 == 0) rv[i] = '{din: 8'sd5, exp_relu: 8'sd5, exp_raw: 8'sd5};
            else            rv[i] = '{din: -8'sd3, exp_relu: 8'sd0, exp_raw: -8'sd3};
        end
        rv[21] = '{din: -8'sd1, exp_relu: 8'sd0, exp_raw: -8'sd1};
        rv[22] = '{din: 8'sd0, exp_relu: 8'sd0, exp_raw: 8'sd0};
        rv[23] = '{din: -8'sd128, exp_relu: 8'sd0, exp_raw: -8'sd128};
        rv[24] = '{din: 8'sd127, exp_relu: 8'sd127, exp_raw: 8'sd127};

        // Reset values
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        nreset = 1'b1;
        @(posedge clock); #1;

        // Start handshake timing, in_valid ignored in IDLE, start ignored in FILL
        for (int i = 0; i < 4; i++) begin
            start    = cv[i].start;
            in_valid = cv[i].in_valid;
            in_data  = 8'sh77;
            @(negedge clock);
            chk("ctl_in_ready", in_ready, cv[i].exp_in_ready);
            chk("ctl_busy", busy, cv[i].exp_busy);
            chk("ctl_out_valid", out_valid, 0);
            @(posedge clock); #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Basic capture 1..25
        set_ramp(1);
        feed(0, -1, 25);
        drain(-1, 0, 0);
        repeat (2) @(posedge clock);
        #1;

        // ReLU table
        for (int i = 0; i < 25; i++) begin
            cur[i]   = rv[i].din;
            exp_r[i] = rv[i].exp_relu;
            exp_n[i] = rv[i].exp_raw;
        end
        do_start();
        feed(0, -1, 25);
        drain(-1, 0, 0);
        repeat (2) @(posedge clock);
        #1;

        // Input gaps and output stall at element 12
        set_ramp(30);
        do_start();
        feed(1, -1, 25);
        drain(12, 3, 0);
        repeat (2) @(posedge clock);
        #1;

        // Ignored events: in_valid in IDLE, start mid-FILL, start/in_valid in DRAIN
        in_valid = 1'b1;
        in_data  = 8'sh66;
        repeat (2) @(posedge clock);
        #1;
        in_valid = 1'b0;
        set_ramp(1);
        do_start();
        feed(0, 7, 25);
        drain(-1, 0, 1);
        repeat (2) @(posedge clock);
        #1;

        // Reset after 10 inputs, then a fresh capture
        set_ramp(1);
        do_start();
        feed(0, -1, 10);
        nreset = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_busy", busy, 0);
        set_ramp(60);
        do_start();
        feed(0, -1, 25);
        drain(-1, 0, 0);
        repeat (2) @(posedge clock);
        #1;

        // Back-to-back: start in the done cycle
        set_ramp(1);
        do_start();
        feed(0, -1, 25);
        drain(-1, 0, 0);
        set_ramp(100);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("b2b_in_ready", in_ready, 1);
        feed(0, -1, 25);
        drain(-1, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("end_busy", busy, 0);
        chk("end_pops", pops, 175);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmap_collector.md
# fmap_collector

Sink end of the convolution datapath: accepts the stream of convolution results produced as the 3x3 window slides over the input image, stores them in raster order into an OUT_SIZE x OUT_SIZE output feature map, then streams the completed map back out. It is the writer/reader counterpart to the window-slicing side, which generates the (i, j) window positions. Optional ReLU is applied on write.

## Interface
- OUT_SIZE, 5, output map side (image SIZE − kernel SIZEKer + 1)
- WIDTH_BIT, 8, result width, signed two's complement
- RELU, 1, 1 = clamp negative results to 0 on write; 0 = store unchanged

- clock  in  1  single clock, rising edge
- nreset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a capture when IDLE
- in_valid  in  1  in_data is valid
- in_ready  out  1  collector accepts in_data this cycle
- in_data  in  WIDTH_BIT  convolution result, raster order (row-major)
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  WIDTH_BIT  stored map element, raster order
- out_last  out  1  high with the final element (OUT_SIZE−1, OUT_SIZE−1)
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the final output handshake

## Operation
- States: IDLE, FILL, DRAIN.
- IDLE: in_ready=0, out_valid=0. start=1 → FILL; write and read counters cleared to (0,0).
- FILL: in_ready=1. Each handshake (in_valid & in_ready) writes mem[wr_row][wr_col] ← f(in_data) and advances wr_col; when wr_col = OUT_SIZE−1, wr_col wraps to 0 and wr_row increments. A handshake at (OUT_SIZE−1, OUT_SIZE−1) → DRAIN.
- f(x) = (RELU && x[WIDTH_BIT−1]) ? 0 : x. No other arithmetic; width is preserved.
- DRAIN: in_ready=0, out_valid=1, out_data = mem[rd_row][rd_col] (combinational read at registered counters). Each handshake (out_valid & out_ready) advances the read counter with the same wrap rule. out_last=1 when the read counter is at (OUT_SIZE−1, OUT_SIZE−1). Handshake on the last element → IDLE, done=1 for the next cycle.
- start in FILL or DRAIN is ignored. in_valid outside FILL is ignored; no write occurs.
- out_ready low holds out_data/out_last stable (no advance).
- Memory contents are not reset. They are only read after a full FILL, so their value after reset is don't-care.

## Timing
- Reset values: state IDLE, in_ready=0, out_valid=0, out_last=0, busy=0, done=0, counters (0,0).
- nreset asserted mid-FILL or mid-DRAIN: immediate return to IDLE. Partial capture is discarded. No done pulse.
- start sampled at cycle T → in_ready=1 at T+1.
- Input throughput: one element per cycle. FILL takes at least OUT_SIZE² cycles.
- Final input handshake at cycle N → out_valid=1 with mem[0][0] at N+1. There is zero bubble between the last write and the first read.
- Output throughput: one element per cycle while out_ready=1.
- Final output handshake at cycle M → state IDLE and done=1 at M+1. done=0 at M+2.
- start at M+1 (done cycle) is accepted: FILL at M+2.
- busy is a registered decode of state (≠ IDLE).

## Structure
- Shared package cnn_pkg: state enum (IDLE, FILL, DRAIN); pixel_t = logic signed [WIDTH_BIT−1:0]. This typedef is shared with cnn and the window slicer.
- One sub-module, raster_counter: parameter OUT_SIZE; ports clear, advance, row, col, at_end. It provides row/col counting with wrap and end detect, and is instantiated twice (write side, read side). The counter logic mirrors indexMatrix but is handshake-gated.
- Storage: pixel_t mem [OUT_SIZE][OUT_SIZE], flop array, written in FILL only.

## Test plan
- Basic capture: start; feed 25 values 1..25 with in_valid held high, out_ready=1 → out_data 1..25 on consecutive cycles, out_last on value 25, done one cycle after, busy drops.
- ReLU: RELU=1, feed alternating 8'sd5 / −8'sd3 → readback alternates 5 / 0. With RELU=0 → 5 / 8'hFD.
- Backpressure: in_valid toggled randomly, out_ready low for 3 cycles at element 12 → no duplicated or skipped elements; out_data stable while stalled.
- Ignored events: start pulsed mid-FILL and mid-DRAIN, in_valid high in IDLE and DRAIN → counters and stored data unchanged; output sequence identical to the basic capture.
- Reset mid-operation: nreset low after 10 inputs → all outputs at reset values, no done pulse. A new full capture then reads back correctly.
- Back-to-back frames: start in the done cycle, second frame 100..124 → second readout exactly 100..124, in_ready high one cycle after start.
